// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack with sticky overflow/underflow flags
module return_addr_stack #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic                       clr_err_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_err_i;
        underflow_d = underflow_q & ~clr_err_i;
        we          = 1'b0;
        waddr       = ptr_q;
        if (flush_i) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (push_i && pop_i) begin
            if (!is_empty) begin
                we = 1'b1;
            end else begin
                // Pop of an empty stack collapses to a plain push but is still an error.
                ptr_d       = ptr_q + PTR_ONE;
                waddr       = ptr_q + PTR_ONE;
                we          = 1'b1;
                count_d     = CNT_ONE;
                underflow_d = 1'b1;
            end
        end else if (push_i) begin
            if (!is_full) begin
                ptr_d   = ptr_q + PTR_ONE;
                waddr   = ptr_q + PTR_ONE;
                we      = 1'b1;
                count_d = count_q + CNT_ONE;
            end else begin
                overflow_d = 1'b1;
                if (WRAP_MODE != 0) begin
                    ptr_d = ptr_q + PTR_ONE;
                    waddr = ptr_q + PTR_ONE;
                    we    = 1'b1;
                end
            end
        end else if (pop_i) begin
            if (!is_empty) begin
                ptr_d   = ptr_q - PTR_ONE;
                count_d = count_q - CNT_ONE;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Array holds no reset; its contents are masked by count.
    always_ff @(posedge clk_i) begin
        if (we && reset_ni) begin
            mem_q[waddr] <= din_i;
        end
    end

    assign dout_o      = is_empty ? '0 : mem_q[ptr_q];
    assign count_o     = count_q;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
